// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending scoreboard.
//   clk, nreset         : rising-edge clock, asynchronous active-low reset
//   wr_valid/addr/data  : WP write ports; the highest index wins on an address clash
//   alloc_valid/addr    : marks one register pending (a new producer was issued)
//   rd_valid/addr       : RP independent read ports
//   rd_data/rd_pend     : per-port read value and pending flag, RL cycles after the request
//   pend_vec            : registered scoreboard, bit i = register i pending
// Flat port vectors carry port k of a group at [k*W +: W].

// One read port: resolves write bypass and zero-register masking, then
// presents the result either combinationally (RL=0) or registered (RL=1).
module regfile_sb_rport #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int WP       = 2,
  parameter int RL       = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WP-1:0]    wr_valid,
  input  logic [WP*AW-1:0] wr_addr,
  input  logic [WP*DW-1:0] wr_data,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_addr,
  input  logic [DW-1:0]    word,
  input  logic             pend_bit,
  output logic [DW-1:0]    rd_data,
  output logic             rd_pend
);
  logic          hit;
  logic [DW-1:0] byp;
  logic          alloc_hit;
  logic [DW-1:0] eff_data;
  logic          eff_pend;

  // Ascending scan so the last match (highest port index) supplies the data,
  // matching the write priority applied to the array.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int j = 0; j < WP; j++) begin
      if (wr_valid[j] && wr_addr[j*AW +: AW] == rd_addr) begin
        hit = 1'b1;
        byp = wr_data[j*DW +: DW];
      end
    end
  end

  assign alloc_hit = alloc_valid && (alloc_addr == rd_addr);

  always_comb begin
    eff_data = '0;
    eff_pend = 1'b0;
    if (rd_valid) begin
      if ((ZERO_REG != 0) && rd_addr == '0) eff_data = '0;
      else if ((BYPASS != 0) && hit)        eff_data = byp;
      else                                  eff_data = word;
      // A forwarded write retires its producer unless a new one is
      // allocated in the same cycle.
      if ((BYPASS != 0) && hit && !alloc_hit) eff_pend = 1'b0;
      else                                    eff_pend = pend_bit;
    end
  end

  if (RL == 0) begin : g_rl0
    assign rd_data = eff_data;
    assign rd_pend = eff_pend;
  end else begin : g_rl1
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        rd_data <= '0;
        rd_pend <= 1'b0;
      end else if (rd_valid) begin
        rd_data <= eff_data;
        rd_pend <= eff_pend;
      end
    end
  end
endmodule

module regfile_sb #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int RP       = 2,
  parameter int WP       = 2,
  parameter int RL       = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [WP-1:0]       wr_valid,
  input  logic [WP*AW-1:0]    wr_addr,
  input  logic [WP*DW-1:0]    wr_data,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  input  logic [RP-1:0]       rd_valid,
  input  logic [RP*AW-1:0]    rd_addr,
  output logic [RP*DW-1:0]    rd_data,
  output logic [RP-1:0]       rd_pend,
  output logic [(1<<AW)-1:0]  pend_vec
);
  localparam int REGS = 1 << AW;

  if (RL != 0 && RL != 1) begin : g_bad_rl
    $error("regfile_sb: RL must be 0 or 1");
  end

  logic [REGS-1:0][DW-1:0] mem;
  logic [REGS-1:0]         pend;

  // Later loop iterations override earlier NBAs, so the highest-index port
  // wins both the data and the pending clear; alloc is applied last so it
  // beats a same-cycle write to the same register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem  <= '0;
      pend <= '0;
    end else begin
      for (int j = 0; j < WP; j++) begin
        if (wr_valid[j] && !((ZERO_REG != 0) && wr_addr[j*AW +: AW] == '0))
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        if (wr_valid[j])
          pend[wr_addr[j*AW +: AW]] <= 1'b0;
      end
      if (alloc_valid && !((ZERO_REG != 0) && alloc_addr == '0))
        pend[alloc_addr] <= 1'b1;
    end
  end

  assign pend_vec = pend;

  for (genvar i = 0; i < RP; i++) begin : g_rport
    regfile_sb_rport #(
      .AW(AW), .DW(DW), .WP(WP), .RL(RL), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rport (
      .clk         (clk),
      .nreset      (nreset),
      .rd_valid    (rd_valid[i]),
      .rd_addr     (rd_addr[i*AW +: AW]),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .word        (mem[rd_addr[i*AW +: AW]]),
      .pend_bit    (pend[rd_addr[i*AW +: AW]]),
      .rd_data     (rd_data[i*DW +: DW]),
      .rd_pend     (rd_pend[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench: three configurations share one stimulus stream.
//   A: RL=1 BYPASS=1 ZERO_REG=1   B: RL=0 BYPASS=0 ZERO_REG=0   C: RL=1 BYPASS=0 ZERO_REG=0
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  wr_valid;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic [1:0]  rd_valid;
  logic [9:0]  rd_addr;
  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rp_a, rp_b, rp_c;
  logic [31:0] pv_a, pv_b, pv_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(.RL(1), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .nreset(nreset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_a), .rd_pend(rp_a), .pend_vec(pv_a));
  regfile_sb #(.RL(0), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .nreset(nreset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_b), .rd_pend(rp_b), .pend_vec(pv_b));
  regfile_sb #(.RL(1), .BYPASS(0), .ZERO_REG(0)) dut_c (
    .clk(clk), .nreset(nreset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_c), .rd_pend(rp_c), .pend_vec(pv_c));

  // Read port 0 reads ra0 and port 1 reads ra1, both valid, every vector.
  // a*/c* are sampled after the edge; b* is sampled combinationally before it.
  typedef struct {
    logic [1:0]  wv;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic        av;  logic [4:0]  aa;
    logic [4:0]  ra0; logic [4:0]  ra1;
    logic [31:0] a0;  logic        ap0; logic [31:0] a1;
    logic [31:0] b0;  logic        bp0;
    logic [31:0] c0;  logic        cp0;
    logic [31:0] pva;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  vec_t qa [$];
  vec_t qb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_valid = '0; wr_addr = '0; wr_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0;
    rd_valid = '0; rd_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    wr_valid    = v.wv;
    wr_addr     = {v.wa1, v.wa0};
    wr_data     = {v.wd1, v.wd0};
    alloc_valid = v.av;
    alloc_addr  = v.aa;
    rd_valid    = 2'b11;
    rd_addr     = {v.ra1, v.ra0};
  endtask

  initial begin
    vec_t e;
    //          wv    wa0 wd0           wa1 wd1      av aa  ra0 ra1 a0            ap0 a1        b0            bp0 c0            cp0 pva
    vecs[0]  = '{2'b11, 3, 32'h1111,     3, 32'h2222, 0, 0,  3, 3, 32'h2222,     0, 32'h2222, 32'h0,        0, 32'h0,        0, 32'h0};
    vecs[1]  = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  3, 3, 32'h2222,     0, 32'h2222, 32'h2222,     0, 32'h2222,     0, 32'h0};
    vecs[2]  = '{2'b01, 3, 32'h1111,     0, 32'h0,    0, 0,  3, 3, 32'h1111,     0, 32'h1111, 32'h2222,     0, 32'h2222,     0, 32'h0};
    vecs[3]  = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  3, 3, 32'h1111,     0, 32'h1111, 32'h1111,     0, 32'h1111,     0, 32'h0};
    vecs[4]  = '{2'b01, 7, 32'hCAFE,     0, 32'h0,    0, 0,  7, 3, 32'hCAFE,     0, 32'h1111, 32'h0,        0, 32'h0,        0, 32'h0};
    vecs[5]  = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  7, 3, 32'hCAFE,     0, 32'h1111, 32'hCAFE,     0, 32'hCAFE,     0, 32'h0};
    vecs[6]  = '{2'b01, 0, 32'hFFFFFFFF, 0, 32'h0,    1, 0,  0, 3, 32'h0,        0, 32'h1111, 32'h0,        0, 32'h0,        0, 32'h0};
    vecs[7]  = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  0, 3, 32'h0,        0, 32'h1111, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 32'h0};
    vecs[8]  = '{2'b00, 0, 32'h0,        0, 32'h0,    1, 9,  9, 3, 32'h0,        0, 32'h1111, 32'h0,        0, 32'h0,        0, 32'h200};
    vecs[9]  = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  9, 3, 32'h0,        1, 32'h1111, 32'h0,        1, 32'h0,        1, 32'h200};
    vecs[10] = '{2'b10, 0, 32'h0,        9, 32'h55,   0, 0,  9, 3, 32'h55,       0, 32'h1111, 32'h0,        1, 32'h0,        1, 32'h0};
    vecs[11] = '{2'b01, 9, 32'h66,       0, 32'h0,    1, 9,  9, 3, 32'h66,       0, 32'h1111, 32'h55,       0, 32'h55,       0, 32'h200};
    vecs[12] = '{2'b00, 0, 32'h0,        0, 32'h0,    0, 0,  9, 3, 32'h66,       1, 32'h1111, 32'h66,       1, 32'h66,       1, 32'h200};

    idle();
    #1;
    chk("rst_rd_a", rd_a, 64'h0);
    chk("rst_pv_a", {32'h0, pv_a}, 64'h0);
    chk("rst_rd_b", rd_b, 64'h0);
    @(negedge clk);
    nreset = 1'b1;

    // Table-driven body with queued expectations.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      qb.push_back(vecs[i]);
      qa.push_back(vecs[i]);
      #1;
      e = qb.pop_front();
      chk($sformatf("v%0d_b_data", i), {32'h0, rd_b[31:0]}, {32'h0, e.b0});
      chk($sformatf("v%0d_b_pend", i), {63'h0, rp_b[0]}, {63'h0, e.bp0});
      @(posedge clk);
      #1;
      e = qa.pop_front();
      chk($sformatf("v%0d_a_data", i), rd_a, {e.a1, e.a0});
      chk($sformatf("v%0d_a_pend", i), {63'h0, rp_a[0]}, {63'h0, e.ap0});
      chk($sformatf("v%0d_c_data", i), {32'h0, rd_c[31:0]}, {32'h0, e.c0});
      chk($sformatf("v%0d_c_pend", i), {63'h0, rp_c[0]}, {63'h0, e.cp0});
      chk($sformatf("v%0d_a_pvec", i), {32'h0, pv_a}, {32'h0, e.pva});
    end
    // Non-zero-register config keeps the alloc of r0 and r9.
    chk("pv_b_r0_r9", {32'h0, pv_b}, 64'h201);

    // Mid-cycle asynchronous reset, with a write in flight that must be lost.
    @(negedge clk);
    idle();
    wr_valid = 2'b01; wr_addr = 10'd5; wr_data = 64'h5A5A;
    #2 nreset = 1'b0;
    #1;
    chk("async_rd_a", rd_a, 64'h0);
    chk("async_rp_a", {62'h0, rp_a}, 64'h0);
    chk("async_pv_a", {32'h0, pv_a}, 64'h0);
    chk("async_pv_b", {32'h0, pv_b}, 64'h0);
    chk("async_rd_c", rd_c, 64'h0);
    @(negedge clk);
    idle();
    nreset = 1'b1;
    rd_valid = 2'b01; rd_addr = 10'd5;
    #1 chk("post_rst_r5_b", rd_b, 64'h0);
    @(posedge clk);
    #1 chk("post_rst_r5_a", rd_a, 64'h0);

    // Hold and gating on read port 1.
    @(negedge clk);
    idle();
    wr_valid = 2'b01; wr_addr = 10'd2; wr_data = 64'hAB;
    @(negedge clk);
    idle();
    rd_valid = 2'b10; rd_addr = {5'd2, 5'd0};
    #1 chk("hold_b_read", {32'h0, rd_b[63:32]}, 64'hAB);
    @(posedge clk);
    #1 chk("hold_a_read", {32'h0, rd_a[63:32]}, 64'hAB);
    @(negedge clk);
    idle();
    wr_valid = 2'b01; wr_addr = 10'd2; wr_data = 64'hCD;
    rd_addr = {5'd2, 5'd0};
    #1 chk("gate_b_zero", {32'h0, rd_b[63:32]}, 64'h0);
    @(posedge clk);
    #1 chk("hold_a_keep", {32'h0, rd_a[63:32]}, 64'hAB);
    @(negedge clk);
    idle();
    rd_valid = 2'b10; rd_addr = {5'd2, 5'd0};
    @(posedge clk);
    #1 chk("hold_a_new", {32'h0, rd_a[63:32]}, 64'hCD);
    chk("hold_c_new", {32'h0, rd_c[63:32]}, 64'hCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
